// File: rtl/carfield_pkg.sv
// Shared Carfield types and constants for the island power/boot sequencer.
package carfield_pkg;

  typedef enum logic [1:0] {
    SafetyIslandIdx   = 2'd0,
    SecurityIslandIdx = 2'd1,
    IntClusterIdx     = 2'd2
  } island_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    UP_CLK,
    UP_RST,
    UP_ISO,
    DN_ISO,
    DN_RST
  } boot_seq_state_e;

  localparam int unsigned IslandSettleCycles  = 16;
  localparam int unsigned IntClusterBootAddrW = 32;

  // Round-robin successor of an island index.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/carfield_rr_picker.sv
// Combinational round-robin search: first set bit at or after the pointer, with wrap-around.
module carfield_rr_picker #(
  parameter int unsigned NumIslands = 3,
  parameter int unsigned IdxW       = 2
) (
  input  logic [NumIslands-1:0] pending,
  input  logic [IdxW-1:0]       ptr,
  output logic                  valid,
  output logic [IdxW-1:0]       idx
);

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NumIslands - 1; k >= 0; k--) begin
      if (pending[(int'(ptr) + k) % NumIslands]) begin
        valid = 1'b1;
        idx   = IdxW'((int'(ptr) + k) % NumIslands);
      end
    end
  end

endmodule

// File: rtl/carfield_island_boot_ctrl.sv
// Shared power/boot sequencer: steps clock, reset, isolation and fetch-enable of one island at a time.
module carfield_island_boot_ctrl
  import carfield_pkg::*;
#(
  parameter int unsigned NumIslands   = 3,
  parameter int unsigned SettleCycles = IslandSettleCycles,
  parameter int unsigned CntWidth     = 8,
  parameter int unsigned BootAddrW    = IntClusterBootAddrW,
  localparam int unsigned IdxW        = (NumIslands > 1) ? $clog2(NumIslands) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumIslands-1:0]           target_on_i,
  input  logic [NumIslands*BootAddrW-1:0] boot_addr_i,
  output logic [NumIslands-1:0]           clk_en_o,
  output logic [NumIslands-1:0]           rst_no,
  output logic [NumIslands-1:0]           iso_o,
  output logic [NumIslands-1:0]           fetch_en_o,
  output logic [NumIslands*BootAddrW-1:0] boot_addr_o,
  output logic [NumIslands-1:0]           island_on_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [IdxW-1:0]                 done_idx_o
);

  if (SettleCycles < 1 || SettleCycles > 2 ** CntWidth) begin : g_bad_settle
    $error("SettleCycles must lie in 1..2**CntWidth");
  end
  if (NumIslands < 1 || NumIslands > 8) begin : g_bad_islands
    $error("NumIslands must lie in 1..8");
  end

  localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SettleCycles - 1);

  boot_seq_state_e                 state_q, state_d;
  logic [CntWidth-1:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]                 cur_q, cur_d, ptr_q, ptr_d;
  logic [NumIslands-1:0]           clk_en_q, clk_en_d, rst_n_q, rst_n_d, iso_q, iso_d;
  logic [NumIslands-1:0]           fetch_en_q, fetch_en_d, island_on_q, island_on_d;
  logic [NumIslands*BootAddrW-1:0] boot_addr_q, boot_addr_d;
  logic                            busy_q, busy_d, done_q, done_d;
  logic [IdxW-1:0]                 done_idx_q, done_idx_d;
  logic                            pick_valid, settle_done;
  logic [IdxW-1:0]                 pick_idx;

  carfield_rr_picker #(
    .NumIslands (NumIslands),
    .IdxW       (IdxW)
  ) i_picker (
    .pending (target_on_i ^ island_on_q),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  assign settle_done = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    ptr_d       = ptr_q;
    clk_en_d    = clk_en_q;
    rst_n_d     = rst_n_q;
    iso_d       = iso_q;
    fetch_en_d  = fetch_en_q;
    boot_addr_d = boot_addr_q;
    island_on_d = island_on_q;
    done_d      = 1'b0;
    done_idx_d  = done_idx_q;
    if (state_q != IDLE && !settle_done) cnt_d = cnt_q - CntWidth'(1);
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cur_d = pick_idx;
          ptr_d = IdxW'(rr_next(int'(pick_idx), NumIslands));
          cnt_d = SettleLoad;
          if (target_on_i[pick_idx]) begin
            state_d            = UP_CLK;
            clk_en_d[pick_idx] = 1'b1;
            boot_addr_d[pick_idx*BootAddrW +: BootAddrW] = boot_addr_i[pick_idx*BootAddrW +: BootAddrW];
          end else begin
            state_d              = DN_ISO;
            fetch_en_d[pick_idx] = 1'b0;
            iso_d[pick_idx]      = 1'b1;
          end
        end
      end
      UP_CLK: if (settle_done) begin
        state_d        = UP_RST;
        cnt_d          = SettleLoad;
        rst_n_d[cur_q] = 1'b1;
      end
      UP_RST: if (settle_done) begin
        state_d      = UP_ISO;
        cnt_d        = SettleLoad;
        iso_d[cur_q] = 1'b0;
      end
      UP_ISO: if (settle_done) begin
        state_d            = IDLE;
        fetch_en_d[cur_q]  = 1'b1;
        island_on_d[cur_q] = 1'b1;
        done_d             = 1'b1;
        done_idx_d         = cur_q;
      end
      DN_ISO: if (settle_done) begin
        state_d        = DN_RST;
        cnt_d          = SettleLoad;
        rst_n_d[cur_q] = 1'b0;
      end
      DN_RST: if (settle_done) begin
        state_d            = IDLE;
        clk_en_d[cur_q]    = 1'b0;
        island_on_d[cur_q] = 1'b0;
        done_d             = 1'b1;
        done_idx_d         = cur_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      ptr_q       <= '0;
      clk_en_q    <= '0;
      rst_n_q     <= '0;
      iso_q       <= '1;
      fetch_en_q  <= '0;
      boot_addr_q <= '0;
      island_on_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      ptr_q       <= ptr_d;
      clk_en_q    <= clk_en_d;
      rst_n_q     <= rst_n_d;
      iso_q       <= iso_d;
      fetch_en_q  <= fetch_en_d;
      boot_addr_q <= boot_addr_d;
      island_on_q <= island_on_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_idx_q  <= done_idx_d;
    end
  end

  assign clk_en_o    = clk_en_q;
  assign rst_no      = rst_n_q;
  assign iso_o       = iso_q;
  assign fetch_en_o  = fetch_en_q;
  assign boot_addr_o = boot_addr_q;
  assign island_on_o = island_on_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign done_idx_o  = done_idx_q;

  // An island may only fetch when clocked, out of reset and de-isolated.
  for (genvar gi = 0; gi < NumIslands; gi++) begin : g_inv
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      fetch_en_q[gi] |-> (!iso_q[gi] && rst_n_q[gi] && clk_en_q[gi]));
    assert property (@(posedge clk_i) disable iff (!rst_ni) rst_n_q[gi] |-> clk_en_q[gi]);
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) $countones(clk_en_q ^ $past(clk_en_q)) <= 1);
  assert property (@(posedge clk_i) disable iff (!rst_ni) $countones(rst_n_q ^ $past(rst_n_q)) <= 1);
  assert property (@(posedge clk_i) disable iff (!rst_ni) $countones(iso_q ^ $past(iso_q)) <= 1);
  assert property (@(posedge clk_i) disable iff (!rst_ni) $countones(fetch_en_q ^ $past(fetch_en_q)) <= 1);
  assert property (@(posedge clk_i) disable iff (!rst_ni) $countones(island_on_q ^ $past(island_on_q)) <= 1);

endmodule

// File: tb/tb_carfield_island_boot_ctrl.sv
// Scoreboard bench for the island boot sequencer: directed targets, expected completions queued.
module tb_carfield_island_boot_ctrl;

  localparam int N  = 3;
  localparam int S  = 16;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    target_on = '0;
  logic [N*AW-1:0] boot_addr_in = '0;
  logic [N-1:0]    clk_en, rst_no, iso, fetch_en, island_on;
  logic [N*AW-1:0] boot_addr;
  logic            busy, done;
  logic [1:0]      done_idx;

  carfield_island_boot_ctrl #(
    .NumIslands   (N),
    .SettleCycles (S),
    .CntWidth     (8),
    .BootAddrW    (AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .target_on_i (target_on),
    .boot_addr_i (boot_addr_in),
    .clk_en_o    (clk_en),
    .rst_no      (rst_no),
    .iso_o       (iso),
    .fetch_en_o  (fetch_en),
    .boot_addr_o (boot_addr),
    .island_on_o (island_on),
    .busy_o      (busy),
    .done_o      (done),
    .done_idx_o  (done_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int t;

  typedef struct {
    int idx;
    bit up;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input int idx, input bit up, input int c);
    exp_t e;
    e.idx = idx;
    e.up  = up;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_clk_en"}, clk_en, 3'b000);
    check({tag, "_rst_no"}, rst_no, 3'b000);
    check({tag, "_iso"}, iso, 3'b111);
    check({tag, "_fetch_en"}, fetch_en, 3'b000);
    check({tag, "_boot_addr"}, boot_addr, 96'h0);
    check({tag, "_island_on"}, island_on, 3'b000);
    check({tag, "_busy_done"}, {busy, done, done_idx}, 4'b0000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    target_on = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Completion monitor: every done pulse must match the oldest queued expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: idx=%0d at cycle %0d, required no completion", done_idx, cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_idx", done_idx, e.idx);
          check("done_cycle", cyc, e.cyc);
          check("done_island_on", island_on[e.idx], e.up);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Single power-up of island 0 with step timing.
    do_reset();
    boot_addr_in = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    target_on = 3'b001;
    t = cyc + 1;
    expect_done(0, 1'b1, t + 3 * S);
    go(t);
    check("up_clk_en", {clk_en, rst_no, busy}, {3'b001, 3'b000, 1'b1});
    go(t + S - 1);     check("up_rst_pre", rst_no, 3'b000);
    go(t + S);         check("up_rst", {rst_no, iso}, {3'b001, 3'b111});
    go(t + 2 * S - 1); check("up_iso_pre", iso, 3'b111);
    go(t + 2 * S);     check("up_iso", {iso, fetch_en}, {3'b110, 3'b000});
    go(t + 3 * S - 1); check("up_fetch_pre", fetch_en, 3'b000);
    go(t + 3 * S);     check("up_fetch", {fetch_en, island_on}, {3'b001, 3'b001});
    check("up_boot_addr", boot_addr, {64'h0, 32'h1000_0000});
    go(t + 3 * S + 1); check("up_idle", {busy, done}, 2'b00);

    // Island 1 up, then power-down with step timing.
    do_reset();
    target_on = 3'b010;
    t = cyc + 1;
    expect_done(1, 1'b1, t + 3 * S);
    go(t + 3 * S + 2);
    target_on = 3'b000;
    t = cyc + 1;
    expect_done(1, 1'b0, t + 2 * S);
    go(t);         check("dn_iso", {iso, fetch_en, rst_no}, {3'b111, 3'b000, 3'b010});
    go(t + S);     check("dn_rst", {rst_no, clk_en}, {3'b000, 3'b010});
    go(t + 2 * S); check("dn_clk", {clk_en, island_on}, {3'b000, 3'b000});
    go(t + 2 * S + 2);

    // All three requested at once: served 0,1,2 with a one-cycle IDLE gap.
    do_reset();
    target_on = 3'b111;
    t = cyc + 1;
    expect_done(0, 1'b1, t + 48);
    expect_done(1, 1'b1, t + 97);
    expect_done(2, 1'b1, t + 146);
    go(t + 48);  check("rr_gap_busy", busy, 1'b0);
    go(t + 49);  check("rr_next_start", {busy, clk_en}, {1'b1, 3'b011});
    go(t + 148); check("rr_all_on", {island_on, busy}, {3'b111, 1'b0});

    // Target glitch during UP_RST: no reaction after completion.
    do_reset();
    target_on = 3'b001;
    t = cyc + 1;
    expect_done(0, 1'b1, t + 48);
    go(t + 20); target_on = 3'b000;
    go(t + 23); target_on = 3'b001;
    go(t + 48); check("glitch_fetch", fetch_en, 3'b001);
    go(t + 60); check("glitch_stable", {island_on, busy}, {3'b001, 1'b0});

    // Target held low during UP_RST: power-down follows one cycle after up-done.
    do_reset();
    target_on = 3'b001;
    t = cyc + 1;
    expect_done(0, 1'b1, t + 48);
    expect_done(0, 1'b0, t + 81);
    go(t + 20); target_on = 3'b000;
    go(t + 48); check("rev_up_iso", iso, 3'b110);
    go(t + 49); check("rev_dn_start", {iso, fetch_en}, {3'b111, 3'b000});
    go(t + 83); check("rev_off", {island_on, clk_en}, {3'b000, 3'b000});

    // Asynchronous reset during UP_ISO, then full restart.
    do_reset();
    target_on = 3'b001;
    t = cyc + 1;
    go(t + 40);
    check("mid_up_iso", iso, 3'b110);
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = cyc + 1;
    expect_done(0, 1'b1, t + 48);
    go(t);      check("restart_clk", {clk_en, rst_no}, {3'b001, 3'b000});
    go(t + 16); check("restart_rst", rst_no, 3'b001);
    go(t + 48); check("restart_fetch", fetch_en, 3'b001);
    go(t + 50);

    // Pointer wraps: island 2 first, then 0, then 1; boot address latched at start.
    do_reset();
    boot_addr_in = '0;
    target_on = 3'b100;
    t = cyc + 1;
    expect_done(2, 1'b1, t + 48);
    go(t + 10);
    boot_addr_in[31:0]  = 32'h7800_0000;
    boot_addr_in[63:32] = 32'h7900_0000;
    target_on = 3'b111;
    expect_done(0, 1'b1, t + 97);
    expect_done(1, 1'b1, t + 146);
    go(t + 20);  check("wrap_hold_others", {clk_en, iso}, {3'b100, 3'b111});
    go(t + 50);  check("wrap_clk_en", clk_en, 3'b101);
    check("wrap_boot0", boot_addr[31:0], 32'h7800_0000);
    boot_addr_in[31:0] = 32'h0;
    go(t + 52);  check("wrap_boot0_held", boot_addr[31:0], 32'h7800_0000);
    go(t + 148); check("wrap_all_on", island_on, 3'b111);
    check("wrap_boot1", boot_addr[63:32], 32'h7900_0000);

    go(cyc + 5);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
